// File: rtl/tpu_out_writer.sv
// Drains one 5x5 result tile from the systolic array into GBUFF_OUT, one packed row per write.
// Optional build macro TPU_OUT_SATURATE_EN: clamp accumulators to int8 instead of truncating.
module tpu_out_writer #(
    parameter int ARRAY  = 5,
    parameter int ACC_W  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              n,
    input  logic                    tile_start,
    input  logic [3:0]              tile_row,
    input  logic [1:0]              tile_col,
    input  logic [2:0]              rows_valid,
    input  logic [2:0]              cols_valid,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [ARRAY*ACC_W-1:0]  res_data,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [ARRAY*DATA_W-1:0] wr_data,
    output logic                    busy,
    output logic                    tile_done
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                    r_state;
    logic [3:0]                r_tile_row;
    logic [1:0]                r_tile_col;
    logic [2:0]                r_rows;
    logic [2:0]                r_cols;
    logic [1:0]                r_row_off;
    logic [2:0]                r_row;
    logic                      r_res_ready;
    logic                      r_wr_en;
    logic                      r_busy;
    logic                      r_tile_done;
    logic [ADDR_W-1:0]         r_wr_addr;
    logic [ARRAY*DATA_W-1:0]   r_wr_data;

    logic [2:0]                w_rows_eff;
    logic [2:0]                w_cols_eff;
    logic [1:0]                w_row_off;
    logic                      w_accept;
    logic                      w_last;
    logic [ADDR_W-1:0]         w_addr;
    logic [ARRAY*DATA_W-1:0]   w_data;
    logic                      w_unused_hi;

`ifdef TPU_OUT_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 <<< (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 <<< (DATA_W-1)));

    function automatic logic [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] acc);
        if (acc > SAT_HI)
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (acc < SAT_LO)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return acc[DATA_W-1:0];
    endfunction
`else
    function automatic logic [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] acc);
        return acc[DATA_W-1:0];
    endfunction
`endif

    // Truncating build ignores the accumulator high bits.
    assign w_unused_hi = ^res_data;

    assign w_rows_eff = (rows_valid == 3'd0) ? 3'd1 : rows_valid;
    assign w_cols_eff = (cols_valid == 3'd0) ? 3'd1 : cols_valid;
    assign w_row_off  = (n <= 4'd5) ? 2'd1 : ((n <= 4'd10) ? 2'd2 : 2'd3);

    assign w_accept = (r_state == S_BUSY) && res_valid && r_res_ready;
    assign w_last   = (r_row == r_rows - 3'd1);
    assign w_addr   = (ADDR_W'(r_tile_row) + ADDR_W'(r_row)) * ADDR_W'(r_row_off)
                    + ADDR_W'(r_tile_col);

    always_comb begin
        w_data = '0;
        for (int c = 0; c < ARRAY; c++) begin
            if (c < int'(r_cols))
                w_data[c*DATA_W +: DATA_W] = narrow(res_data[c*ACC_W +: ACC_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_res_ready <= 1'b0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_tile_done <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_tile_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tile_start) begin
                        r_tile_row  <= tile_row;
                        r_tile_col  <= tile_col;
                        r_rows      <= w_rows_eff;
                        r_cols      <= w_cols_eff;
                        r_row_off   <= w_row_off;
                        r_row       <= '0;
                        r_res_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_addr;
                        r_wr_data <= w_data;
                        r_row     <= r_row + 3'd1;
                        // Done pulse lands in the same cycle as the final write.
                        if (w_last) begin
                            r_res_ready <= 1'b0;
                            r_tile_done <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res_ready = r_res_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;
    assign tile_done = r_tile_done;

endmodule

// File: doc/tpu_out_writer.md
Name: tpu_out_writer

Overview:
- Write-side producer for the output global buffer (GBUFF_OUT) in the 5x5 TPU.
- Drains one 5x5 result tile from the systolic array, one result row per handshake.
- Narrows each accumulator to 8 bits and packs 5 columns into one 40-bit word.
- Writes each word at the row-major address that the top-level bench reads back and checks against golden.

Parameters:
- ARRAY, 5, systolic array dimension (columns per output word).
- ACC_W, 16, accumulator width per PE, two's complement.
- DATA_W, 8, stored element width.
- ADDR_W, 8, GBUFF_OUT address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- n  input  4  MATRIX_B column count (1..15); sampled at tile_start
- tile_start  input  1  pulse: begin draining a tile; ignored unless IDLE
- tile_row  input  4  first matrix row of tile
- tile_col  input  2  column-tile index (0..2)
- rows_valid  input  3  rows to drain, 1..5 (0 treated as 1)
- cols_valid  input  3  valid columns, 1..5 (0 treated as 1)
- res_valid  input  1  array presents one result row
- res_ready  output  1  writer accepts row
- res_data  input  ARRAY*ACC_W  row results; column c at [c*ACC_W +: ACC_W]
- wr_en  output  1  GBUFF_OUT write strobe
- wr_addr  output  ADDR_W  GBUFF_OUT address
- wr_data  output  ARRAY*DATA_W  packed word
- busy  output  1  tile in progress
- tile_done  output  1  one-cycle pulse after last row written

Behaviour:
- Interface: one clock, clk; reset is rst, synchronous and active-high.
- Reset state: res_ready, wr_en, busy, tile_done = 0; wr_addr, wr_data = 0; FSM = IDLE; row counter = 0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE -> BUSY on tile_start.
  - Latch tile_row, tile_col, rows_valid, cols_valid.
  - Latch row_offset = 1 if n<=5, 2 if n<=10, else 3. Equivalent to (n-1)/5+1; no divider.
- BUSY:
  - res_ready = 1.
  - Each cycle with res_valid & res_ready, register one write on the next cycle (1-cycle latency):
    - wr_en = 1
    - wr_addr = (tile_row + r) * row_offset + tile_col, where r = row counter
    - wr_data byte c ([c*8 +: 8]) = narrowed column c.
  - Column 0 goes in [7:0]; column 4 goes in [39:32].
  - Columns c >= cols_valid are written as 0x00.
  - Row counter increments per accepted row.
  - When the accepted row is r = rows_valid-1: drop res_ready the next cycle and go to DONE.
- DONE: tile_done = 1 for exactly one cycle, then return to IDLE. This cycle coincides with the final wr_en.
- busy = 1 in BUSY and DONE.
- Narrowing: take res_data low DATA_W bits (truncation, modulo 256).
- Address arithmetic is unsigned and truncated to ADDR_W; no overflow flag.
- Boundary and edge cases:
  - res_valid low in BUSY: stall, no write, counter held.
  - tile_start while busy: ignored, no effect on latched fields.
  - tile_start coincident with tile_done: ignored; the new tile is accepted from IDLE, one cycle later.
  - rst mid-tile: immediate return to IDLE; the pending write is suppressed (wr_en = 0 next cycle).
  - wr_en is never high outside a registered accepted row.

Optional Feature:
- Macro: TPU_OUT_SATURATE_EN.
- Defined: narrowing saturates the signed ACC_W value to int8.
  - Values > 127 -> 0x7F.
  - Values < -128 -> 0x80.
  - Otherwise low 8 bits.
- Undefined: plain truncation to low 8 bits. This is the golden-matching default.

Test Plan:
- Single full tile: n=5, tile_row=0, tile_col=0, rows/cols_valid=5, rows with acc = r*5+c -> writes at addr 0..4, e.g. addr 2 data = 0x0E0D0C0B0A; tile_done one cycle after 5th accept.
- Partial columns: n=7, tile_col=1, cols_valid=2, tile_row=0, rows_valid=3 -> addrs 1,3,5; bytes [39:16] = 0; row_offset = 2.
- Backpressure: res_valid toggled 1,0,0,1,1,0,1,1 for a 5-row tile -> exactly 5 writes, addresses consecutive, no write during gaps.
- Overflow narrowing: acc 0x0123 and 0xFF80 -> 0x23 / 0x80 by default; with TPU_OUT_SATURATE_EN -> 0x7F / 0x80.
- Reset mid-tile: rst asserted after 2nd accept -> wr_en=0 next cycle, busy=0, no tile_done.
- Then tile_start re-runs cleanly from row 0.
- Start while busy: second tile_start during BUSY with tile_col=2 -> ignored; addresses keep original tile_col.
